// File: rtl/coreaxi4dmacontroller_int_status_fifo.sv
`default_nettype none
// ============================================================================
// Module  : coreaxi4dmacontroller_int_status_fifo
// Brief   : Per-queue interrupt status FIFO with optional SEC-DED protection
//           and a two-stage registered read path.
// Revision: 1.0 - initial release
// ============================================================================
module coreaxi4dmacontroller_int_status_fifo #(
    parameter int FIFO_WIDTH      = 50,
    parameter int DEPTH           = 4,
    parameter int WATERMARK_DEPTH = 1,
    parameter int ECC             = 1,
    parameter int FAMILY          = 25
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  wrEn,
    input  logic [FIFO_WIDTH-1:0] wrData,
    input  logic                  rdEn,
    output logic [FIFO_WIDTH-1:0] rdData,
    output logic                  fifoFull,
    output logic                  wMarkFull,
    output logic                  fifoEmpty,
    output logic                  overflow,
    output logic                  error_flag_sb_fifo,
    output logic                  error_flag_db_fifo
);

    localparam int c_PTR_W    = $clog2(DEPTH);
    localparam int c_CNT_W    = c_PTR_W + 1;
    localparam int c_HAM_BITS = 6;
    localparam int c_STORED_W = (ECC != 0) ? FIFO_WIDTH + c_HAM_BITS + 1 : FIFO_WIDTH;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WATERMARK_DEPTH < 1 ||
        WATERMARK_DEPTH > DEPTH - 2 || FAMILY < 0 ||
        (ECC != 0 && FIFO_WIDTH > 57)) begin : g_badParams
        $error("coreaxi4dmacontroller_int_status_fifo: illegal parameter set");
    end

    logic [c_STORED_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wrPtr;
    logic [c_PTR_W-1:0]    r_rdPtr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_overflow;
    logic                  r_pipeValid;
    logic [c_STORED_W-1:0] r_pipe;
    logic [FIFO_WIDTH-1:0] r_rdData;
    logic                  r_sb;
    logic                  r_db;

    logic [c_STORED_W-1:0] w_encoded;
    logic [FIFO_WIDTH-1:0] w_decData;
    logic                  w_sb;
    logic                  w_db;
    logic                  w_wrAcc;
    logic                  w_rdAcc;

    assign fifoFull           = (r_count == c_CNT_W'(DEPTH));
    assign fifoEmpty          = (r_count == '0);
    assign wMarkFull          = (r_count >= c_CNT_W'(WATERMARK_DEPTH));
    assign overflow           = r_overflow;
    assign rdData             = r_rdData;
    assign error_flag_sb_fifo = r_sb;
    assign error_flag_db_fifo = r_db;

    // A read frees the head slot in the same edge, so a full FIFO never drops
    // a write that arrives together with a read.
    assign w_rdAcc = rdEn & ~fifoEmpty;
    assign w_wrAcc = wrEn & (~fifoFull | rdEn);

    if (ECC != 0) begin : g_ecc
        // Codeword bit 0 is overall parity; bits 1.. are Hamming positions.
        always_comb begin : p_encode
            logic [c_STORED_W-1:0] cw;
            int k;
            cw = '0;
            k  = 0;
            for (int p = 1; p < c_STORED_W; p++) begin
                if ((p & (p - 1)) != 0) begin
                    cw[p] = wrData[k];
                    k++;
                end
            end
            for (int j = 0; j < c_HAM_BITS; j++) begin
                for (int p = 1; p < c_STORED_W; p++) begin
                    if (((p >> j) & 1) != 0) cw[1 << j] = cw[1 << j] ^ cw[p];
                end
            end
            cw[0]     = ^cw[c_STORED_W-1:1];
            w_encoded = cw;
        end

        always_comb begin : p_decode
            logic [c_STORED_W-1:0] fix;
            logic [c_HAM_BITS-1:0] syn;
            logic                  par;
            int k;
            syn = '0;
            par = ^r_pipe;
            fix = r_pipe;
            w_sb = 1'b0;
            w_db = 1'b0;
            w_decData = '0;
            for (int j = 0; j < c_HAM_BITS; j++) begin
                for (int p = 1; p < c_STORED_W; p++) begin
                    if (((p >> j) & 1) != 0) syn[j] = syn[j] ^ r_pipe[p];
                end
            end
            if (par) begin
                w_sb = 1'b1;
                if (int'(syn) < c_STORED_W) fix[syn] = ~fix[syn];
            end else if (syn != '0) begin
                w_db = 1'b1;
            end
            k = 0;
            for (int p = 1; p < c_STORED_W; p++) begin
                if ((p & (p - 1)) != 0) begin
                    w_decData[k] = fix[p];
                    k++;
                end
            end
        end
    end else begin : g_noEcc
        assign w_encoded = wrData;
        assign w_decData = r_pipe;
        assign w_sb      = 1'b0;
        assign w_db      = 1'b0;
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clock) begin
        if (w_wrAcc) r_mem[r_wrPtr] <= w_encoded;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_pipeValid <= 1'b0;
            r_pipe      <= '0;
            r_rdData    <= '0;
            r_sb        <= 1'b0;
            r_db        <= 1'b0;
        end else begin
            if (w_wrAcc) r_wrPtr <= r_wrPtr + c_PTR_ONE;
            if (w_rdAcc) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
                r_pipe  <= r_mem[r_rdPtr];
            end
            case ({w_wrAcc, w_rdAcc})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (wrEn && !w_wrAcc) r_overflow <= 1'b1;
            r_pipeValid <= w_rdAcc;
            if (r_pipeValid) begin
                r_rdData <= w_decData;
                r_sb     <= w_sb;
                r_db     <= w_db;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coreaxi4dmacontroller_int_status_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_coreaxi4dmacontroller_int_status_fifo
// Brief   : Directed, table-driven bench for the interrupt status FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module tb_coreaxi4dmacontroller_int_status_fifo;

    logic        clock = 1'b0;
    logic        resetn;
    logic        wrEn;
    logic [49:0] wrData;
    logic        rdEn;
    logic [49:0] rdData;
    logic        fifoFull;
    logic        wMarkFull;
    logic        fifoEmpty;
    logic        overflow;
    logic        sbFlag;
    logic        dbFlag;

    int total = 0;
    int bad   = 0;

    coreaxi4dmacontroller_int_status_fifo #(
        .FIFO_WIDTH(50), .DEPTH(4), .WATERMARK_DEPTH(1), .ECC(1), .FAMILY(25)
    ) dut (
        .clock(clock), .resetn(resetn), .wrEn(wrEn), .wrData(wrData), .rdEn(rdEn),
        .rdData(rdData), .fifoFull(fifoFull), .wMarkFull(wMarkFull),
        .fifoEmpty(fifoEmpty), .overflow(overflow),
        .error_flag_sb_fifo(sbFlag), .error_flag_db_fifo(dbFlag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [49:0] d;
        logic        eEmpty;
        logic        eFull;
        logic        eWm;
        logic        eOvf;
        logic [49:0] eData;
    } vec_t;

    vec_t vecs [25];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        wrEn   = 1'b0;
        rdEn   = 1'b0;
        wrData = '0;
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic push(input logic [49:0] d);
        wrEn = 1'b1; wrData = d;
        tick();
        wrEn = 1'b0;
    endtask

    // Pops one word and returns after the data has reached the output.
    task automatic pop();
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        tick();
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic [49:0] d,
                                input logic e, input logic f, input logic w,
                                input logic o, input logic [49:0] q);
        vec_t r;
        r.wr = wr; r.rd = rd; r.d = d;
        r.eEmpty = e; r.eFull = f; r.eWm = w; r.eOvf = o; r.eData = q;
        return r;
    endfunction

    initial begin
        // Flags reflect the row just applied; rdData reflects the previous row's read.
        vecs[0]  = mk(1'b1, 1'b0, 50'h1,   1'b0, 1'b0, 1'b1, 1'b0, 50'h0);
        vecs[1]  = mk(1'b1, 1'b0, 50'h2,   1'b0, 1'b0, 1'b1, 1'b0, 50'h0);
        vecs[2]  = mk(1'b1, 1'b0, 50'h3,   1'b0, 1'b0, 1'b1, 1'b0, 50'h0);
        vecs[3]  = mk(1'b1, 1'b0, 50'h4,   1'b0, 1'b1, 1'b1, 1'b0, 50'h0);
        vecs[4]  = mk(1'b1, 1'b0, 50'h5,   1'b0, 1'b1, 1'b1, 1'b1, 50'h0);
        vecs[5]  = mk(1'b0, 1'b1, 50'h0,   1'b0, 1'b0, 1'b1, 1'b1, 50'h0);
        vecs[6]  = mk(1'b0, 1'b1, 50'h0,   1'b0, 1'b0, 1'b1, 1'b1, 50'h1);
        vecs[7]  = mk(1'b0, 1'b1, 50'h0,   1'b0, 1'b0, 1'b1, 1'b1, 50'h2);
        vecs[8]  = mk(1'b0, 1'b1, 50'h0,   1'b1, 1'b0, 1'b0, 1'b1, 50'h3);
        vecs[9]  = mk(1'b0, 1'b0, 50'h0,   1'b1, 1'b0, 1'b0, 1'b1, 50'h4);
        vecs[10] = mk(1'b0, 1'b1, 50'h0,   1'b1, 1'b0, 1'b0, 1'b1, 50'h4);
        vecs[11] = mk(1'b1, 1'b1, 50'hABC, 1'b0, 1'b0, 1'b1, 1'b1, 50'h4);
        vecs[12] = mk(1'b0, 1'b0, 50'h0,   1'b0, 1'b0, 1'b1, 1'b1, 50'h4);
        vecs[13] = mk(1'b0, 1'b1, 50'h0,   1'b1, 1'b0, 1'b0, 1'b1, 50'h4);
        vecs[14] = mk(1'b0, 1'b0, 50'h0,   1'b1, 1'b0, 1'b0, 1'b1, 50'hABC);
        vecs[15] = mk(1'b1, 1'b0, 50'h10,  1'b0, 1'b0, 1'b1, 1'b1, 50'hABC);
        vecs[16] = mk(1'b1, 1'b0, 50'h11,  1'b0, 1'b0, 1'b1, 1'b1, 50'hABC);
        vecs[17] = mk(1'b1, 1'b0, 50'h12,  1'b0, 1'b0, 1'b1, 1'b1, 50'hABC);
        vecs[18] = mk(1'b1, 1'b0, 50'h13,  1'b0, 1'b1, 1'b1, 1'b1, 50'hABC);
        vecs[19] = mk(1'b1, 1'b1, 50'h14,  1'b0, 1'b1, 1'b1, 1'b1, 50'hABC);
        vecs[20] = mk(1'b0, 1'b1, 50'h0,   1'b0, 1'b0, 1'b1, 1'b1, 50'h10);
        vecs[21] = mk(1'b0, 1'b1, 50'h0,   1'b0, 1'b0, 1'b1, 1'b1, 50'h11);
        vecs[22] = mk(1'b0, 1'b1, 50'h0,   1'b0, 1'b0, 1'b1, 1'b1, 50'h12);
        vecs[23] = mk(1'b0, 1'b1, 50'h0,   1'b1, 1'b0, 1'b0, 1'b1, 50'h13);
        vecs[24] = mk(1'b0, 1'b0, 50'h0,   1'b1, 1'b0, 1'b0, 1'b1, 50'h14);

        do_reset();
        check("rst_empty", 64'(fifoEmpty), 64'd1);
        check("rst_others", {58'd0, fifoFull, wMarkFull, overflow, sbFlag, dbFlag, 1'b0}, 64'd0);
        check("rst_rdData", 64'(rdData), 64'd0);

        // First-word latency
        push(50'h2_0000_0000_0001);
        check("lat_empty_c1", 64'(fifoEmpty), 64'd0);
        check("lat_wm_c1", 64'(wMarkFull), 64'd1);
        tick();
        tick();
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        check("lat_empty_c4", 64'(fifoEmpty), 64'd1);
        check("lat_rdData_c4", 64'(rdData), 64'd0);
        tick();
        check("lat_rdData_c5", 64'(rdData), 64'h2_0000_0000_0001);

        // Table: fill, overflow, drain, empty corner cases, full+wr+rd
        do_reset();
        for (int i = 0; i < 25; i++) begin
            wrEn = vecs[i].wr; rdEn = vecs[i].rd; wrData = vecs[i].d;
            tick();
            check($sformatf("vec%0d_empty", i), 64'(fifoEmpty), 64'(vecs[i].eEmpty));
            check($sformatf("vec%0d_full", i),  64'(fifoFull),  64'(vecs[i].eFull));
            check($sformatf("vec%0d_wm", i),    64'(wMarkFull), 64'(vecs[i].eWm));
            check($sformatf("vec%0d_ovf", i),   64'(overflow),  64'(vecs[i].eOvf));
            check($sformatf("vec%0d_data", i),  64'(rdData),    64'(vecs[i].eData));
            check($sformatf("vec%0d_ecc", i),   64'({sbFlag, dbFlag}), 64'd0);
        end
        wrEn = 1'b0; rdEn = 1'b0;

        // Wrap-around across pointer boundary
        for (int i = 0; i < 10; i++) begin
            push(50'(100 + i));
            check($sformatf("wrap%0d_full", i), 64'(fifoFull), 64'd0);
            pop();
            check($sformatf("wrap%0d_empty", i), 64'(fifoEmpty), 64'd1);
            check($sformatf("wrap%0d_data", i), 64'(rdData), 64'(100 + i));
        end

        // Reset with entries queued and a read in flight
        push(50'h7);
        push(50'h8);
        push(50'h9);
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        #2 resetn = 1'b0;
        #3;
        check("midrst_async_empty", 64'(fifoEmpty), 64'd1);
        #1 resetn = 1'b1;
        tick();
        tick();
        check("midrst_empty", 64'(fifoEmpty), 64'd1);
        check("midrst_rdData", 64'(rdData), 64'd0);
        check("midrst_flags", {59'd0, fifoFull, wMarkFull, overflow, sbFlag, dbFlag}, 64'd0);

        // ECC: single flip, double flip, then a clean word (pointers restart at 0)
        push(50'h3FF);
        dut.r_mem[0][5] = ~dut.r_mem[0][5];
        pop();
        check("ecc_sb_data", 64'(rdData), 64'h3FF);
        check("ecc_sb_flags", 64'({sbFlag, dbFlag}), 64'b10);
        push(50'h3FF);
        dut.r_mem[1][3]  = ~dut.r_mem[1][3];
        dut.r_mem[1][20] = ~dut.r_mem[1][20];
        pop();
        check("ecc_db_flags", 64'({sbFlag, dbFlag}), 64'b01);
        push(50'h155);
        pop();
        check("ecc_clean_data", 64'(rdData), 64'h155);
        check("ecc_clean_flags", 64'({sbFlag, dbFlag}), 64'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
